score_display_driver: RTL and testbench
=======================================

Name: score_display_driver

Overview:
- Downstream consumer of the score counter's two 4-bit digit outputs (val_1 = level digit, val_0 = low digit).
- Time-multiplexes them onto a 4-digit common-anode seven-segment display.
- Latches inputs once per scan frame to prevent tearing, blanks a leading zero, shows a dash for non-decimal values, and blinks the whole display while the level digit is at the win level.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot (100 MHz gives 1 kHz per digit, 250 Hz per frame). Legal range is 2 or more.
- BLINK_FRAMES, 64: scan frames per blink half-period. Legal range is 1 or more.
- WIN_LEVEL, 8: val_1 value that triggers blinking.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: synchronous, active-high.
- val_1, input, 4: level digit from the score counter.
- val_0, input, 4: low digit from the score counter.
- an, output, 4: anode enables, active-low. an[0] is the rightmost digit.
- seg, output, 7: cathodes {g,f,e,d,c,b,a}, active-low.
- dp, output, 1: decimal point, active-low. Always 1 (off).
- frame_tick, output, 1: one-cycle pulse on each frame start.

Behaviour:
- One clock domain. All outputs are registered.
- Reset (synchronous, active-high, sampled on the clock edge) sets:
  - an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0
  - prescaler=0, digit index=3
  - snap_1=0, snap_0=0
  - blink counter=0, blink_phase=0
- Reset asserted mid-scan takes effect on that edge. Display goes dark until the first slot tick.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - slot_tick is internal, high on the cycle where prescaler==REFRESH_DIV-1.
- Digit index:
  - Advances 0→1→2→3→0 on slot_tick only.
  - an, seg, and frame_tick update on the same edge as the index, computed from the new index. There is no extra cycle of latency.
- Frame snapshot:
  - Taken on the slot_tick edge where the index wraps 3→0: snap_1<=val_1, snap_0<=val_0, frame_tick<=1 for that one cycle.
  - The digit-0 pattern driven on that edge uses the incoming val_0 directly.
  - Digits 1–3 in the frame use the snapshot. Input changes mid-frame do not appear until the next frame.
- Digit content:
  - Digit 0: snap_0, always shown.
  - Digit 1: snap_1. Blanked (seg=7'b1111111, anode still driven) when snap_1==0.
  - Digits 2 and 3: always blank segments.
- Anode mapping:
  - an = ~(4'b0001 << index).
  - When blinking is in the off phase, an=4'b1111.
- Decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10–15 = dash 0111111
- Blink:
  - win = (snap_1==WIN_LEVEL).
  - While win, the blink counter counts frame starts 0..BLINK_FRAMES-1. At wrap, blink_phase toggles.
  - blink_phase=1 forces an=4'b1111. seg still updates.
  - While not win, the counter and blink_phase are held at 0, so the display is lit immediately.
  - Leaving win mid-blink restores the display at the next frame start.
  - Entering win always starts in the lit phase.
- Width rules:
  - Prescaler sized by $clog2(REFRESH_DIV).
  - Blink counter sized by $clog2(BLINK_FRAMES)+1.
  - No arithmetic overflow is permitted.

Test Plan (REFRESH_DIV=4, BLINK_FRAMES=2):
1. Reset held 3 cycles, then released → an=1111, seg=1111111, dp=1 until the first slot_tick (cycle 4 after release). Then an=1110, frame_tick=1 for one cycle.
2. val_1=3, val_0=7 steady → per frame, an sequence is 1110, 1101, 1011, 0111, each held 4 cycles. seg sequence is 1111000, 0110000, 1111111, 1111111.
3. val_1=0, val_0=5 → digit 1 seg=1111111 while an=1101; digit 0 seg=0010010.
4. val_0 changes 2→9 during digit 2 of a frame → remainder of the frame unchanged. Next frame, digit 0 shows 0010000 on the wrap edge.
5. val_1=8 → first 2 frames lit, next 2 frames an=1111 throughout, then lit again. Drop val_1 to 7 during a dark frame → lit from the next frame start.
6. val_0=4'hC; also reset asserted mid-digit-2 → dash 0111111 on digit 0. On the reset edge, all outputs return to reset values and the index restarts at 3.

Source files
------------

// File: rtl/score_display_driver.sv
// Scans two score digits onto a 4-digit common-anode seven-segment display.
// Inputs are latched once per frame; leading zero blanked, non-decimal shown as a dash.
module score_display_driver #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter int unsigned WIN_LEVEL    = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] val_1,
  input  logic [3:0] val_0,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned CW = $clog2(BLINK_FRAMES) + 1;
  localparam logic [PW-1:0] PrescMax = PW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CntMax   = CW'(BLINK_FRAMES - 1);
  localparam logic [3:0]    WinVal   = 4'(WIN_LEVEL);
  localparam logic [6:0]    SegBlank = 7'b1111111;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    snap_1_q, snap_1_d, snap_0_q, snap_0_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_tick_q, frame_tick_d;
  logic          slot_tick, wrap;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    slot_tick    = (presc_q == PrescMax);
    wrap         = slot_tick && (idx_q == 2'd3);
    presc_d      = slot_tick ? '0 : presc_q + 1'b1;
    idx_d        = slot_tick ? idx_q + 2'd1 : idx_q;
    snap_1_d     = wrap ? val_1 : snap_1_q;
    snap_0_d     = wrap ? val_0 : snap_0_q;
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    frame_tick_d = wrap;
    if (wrap) begin
      // Counting only continues when both the old and new snapshot are at the win level,
      // so entering win always begins lit and leaving it clears at once.
      if ((val_1 != WinVal) || (snap_1_q != WinVal)) begin
        cnt_d   = '0;
        phase_d = 1'b0;
      end else if (cnt_q == CntMax) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    if (slot_tick) begin
      an_d = phase_d ? 4'b1111 : ~(4'b0001 << idx_d);
      case (idx_d)
        2'd0:    seg_d = decode(val_0);
        2'd1:    seg_d = (snap_1_q == 4'd0) ? SegBlank : decode(snap_1_q);
        default: seg_d = SegBlank;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= 2'd3;
      snap_1_q     <= 4'd0;
      snap_0_q     <= 4'd0;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= SegBlank;
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      snap_1_q     <= snap_1_d;
      snap_0_q     <= snap_0_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = 1'b1;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_score_display_driver.sv
// Directed bench for score_display_driver with REFRESH_DIV=4, BLINK_FRAMES=2.
module tb_score_display_driver;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] val_1 = 4'd3;
  logic [3:0] val_0 = 4'd7;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;
  int         total = 0;
  int         bad = 0;

  score_display_driver #(
    .REFRESH_DIV (4),
    .BLINK_FRAMES(2),
    .WIN_LEVEL   (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .val_1     (val_1),
    .val_0     (val_0),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset();
    tick(3);
    total++; if (an !== 4'b1111) begin bad++; $display("FAIL rst_an got=%b exp=1111", an); end
    total++; if (seg !== 7'b1111111) begin bad++; $display("FAIL rst_seg got=%b exp=1111111", seg); end
    total++; if (dp !== 1'b1) begin bad++; $display("FAIL rst_dp got=%b exp=1", dp); end
    total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL rst_ft got=%b exp=0", frame_tick); end
    reset = 1'b0;
    tick(3);
    total++; if (an !== 4'b1111) begin bad++; $display("FAIL pre_tick_an got=%b exp=1111", an); end
    tick(1);
    total++; if (an !== 4'b1110) begin bad++; $display("FAIL first_an got=%b exp=1110", an); end
    total++; if (frame_tick !== 1'b1) begin bad++; $display("FAIL first_ft got=%b exp=1", frame_tick); end
  endtask

  task automatic test_steady();
    logic [6:0] exp_seg [4];
    exp_seg[0] = 7'b1111000; exp_seg[1] = 7'b0110000;
    exp_seg[2] = 7'b1111111; exp_seg[3] = 7'b1111111;
    for (int s = 0; s < 4; s++) begin
      logic [3:0] exp_an;
      exp_an = ~(4'b0001 << s);
      total++; if (an !== exp_an) begin bad++; $display("FAIL steady_an s=%0d got=%b exp=%b", s, an, exp_an); end
      total++; if (seg !== exp_seg[s]) begin bad++; $display("FAIL steady_seg s=%0d got=%b exp=%b", s, seg, exp_seg[s]); end
      tick(1);
      total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL steady_ft_low s=%0d got=%b exp=0", s, frame_tick); end
      total++; if (an !== exp_an) begin bad++; $display("FAIL steady_hold s=%0d got=%b exp=%b", s, an, exp_an); end
      tick(3);
    end
    total++; if (frame_tick !== 1'b1) begin bad++; $display("FAIL steady_ft got=%b exp=1", frame_tick); end
  endtask

  task automatic test_leading_blank();
    val_1 = 4'd0; val_0 = 4'd5;
    tick(16);
    total++; if (seg !== 7'b0010010) begin bad++; $display("FAIL lz_d0 got=%b exp=0010010", seg); end
    tick(4);
    total++; if (an !== 4'b1101) begin bad++; $display("FAIL lz_an got=%b exp=1101", an); end
    total++; if (seg !== 7'b1111111) begin bad++; $display("FAIL lz_d1 got=%b exp=1111111", seg); end
    tick(12);
  endtask

  task automatic test_snapshot();
    val_1 = 4'd1; val_0 = 4'd2;
    tick(16);
    total++; if (seg !== 7'b0100100) begin bad++; $display("FAIL snap_d0 got=%b exp=0100100", seg); end
    val_1 = 4'd5;
    tick(4);
    total++; if (seg !== 7'b1111001) begin bad++; $display("FAIL snap_d1_old got=%b exp=1111001", seg); end
    tick(4);
    val_0 = 4'd9;
    total++; if (an !== 4'b1011) begin bad++; $display("FAIL snap_d2_an got=%b exp=1011", an); end
    tick(4);
    total++; if (seg !== 7'b1111111) begin bad++; $display("FAIL snap_d3 got=%b exp=1111111", seg); end
    tick(4);
    total++; if (seg !== 7'b0010000) begin bad++; $display("FAIL snap_d0_new got=%b exp=0010000", seg); end
    total++; if (frame_tick !== 1'b1) begin bad++; $display("FAIL snap_ft got=%b exp=1", frame_tick); end
    tick(4);
    total++; if (seg !== 7'b0010010) begin bad++; $display("FAIL snap_d1_new got=%b exp=0010010", seg); end
    tick(12);
  endtask

  task automatic test_blink();
    logic [6:0] dark;
    dark = 7'b1001100;
    val_1 = 4'd8; val_0 = 4'd0;
    tick(16);
    for (int f = 0; f < 7; f++) begin
      for (int s = 0; s < 4; s++) begin
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        exp_an = dark[f] ? 4'b1111 : ~(4'b0001 << s);
        exp_seg = (s == 0) ? 7'b1000000 : (s == 1) ? 7'b0000000 : 7'b1111111;
        total++; if (an !== exp_an) begin bad++; $display("FAIL blink_an f=%0d s=%0d got=%b exp=%b", f, s, an, exp_an); end
        total++; if (seg !== exp_seg) begin bad++; $display("FAIL blink_seg f=%0d s=%0d got=%b exp=%b", f, s, seg, exp_seg); end
        if (f == 6 && s == 1) val_1 = 4'd7;
        tick(4);
      end
    end
    total++; if (an !== 4'b1110) begin bad++; $display("FAIL unblink_an got=%b exp=1110", an); end
    tick(4);
    total++; if (an !== 4'b1101) begin bad++; $display("FAIL unblink_an1 got=%b exp=1101", an); end
    total++; if (seg !== 7'b1111000) begin bad++; $display("FAIL unblink_seg got=%b exp=1111000", seg); end
    tick(12);
  endtask

  task automatic test_dash_reset();
    val_1 = 4'd2; val_0 = 4'hC;
    tick(16);
    total++; if (seg !== 7'b0111111) begin bad++; $display("FAIL dash_seg got=%b exp=0111111", seg); end
    tick(9);
    reset = 1'b1;
    tick(1);
    total++; if (an !== 4'b1111) begin bad++; $display("FAIL midrst_an got=%b exp=1111", an); end
    total++; if (seg !== 7'b1111111) begin bad++; $display("FAIL midrst_seg got=%b exp=1111111", seg); end
    total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL midrst_ft got=%b exp=0", frame_tick); end
    reset = 1'b0;
    tick(3);
    total++; if (an !== 4'b1111) begin bad++; $display("FAIL midrst_dark got=%b exp=1111", an); end
    tick(1);
    total++; if (an !== 4'b1110) begin bad++; $display("FAIL midrst_restart got=%b exp=1110", an); end
    total++; if (frame_tick !== 1'b1) begin bad++; $display("FAIL midrst_ft1 got=%b exp=1", frame_tick); end
    total++; if (seg !== 7'b0111111) begin bad++; $display("FAIL midrst_dash got=%b exp=0111111", seg); end
    tick(4);
    total++; if (seg !== 7'b0100100) begin bad++; $display("FAIL midrst_d1 got=%b exp=0100100", seg); end
    total++; if (dp !== 1'b1) begin bad++; $display("FAIL dp got=%b exp=1", dp); end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_leading_blank();
    test_snapshot();
    test_blink();
    test_dash_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
